tx_frame_builder: RTL and testbench
===================================

TX_FRAME_BUILDER -- requirements
Module: tx_frame_builder

Interface
REQ-001 SHALL have parameter MIN_PAY_WORDS, default 12, minimum payload-section words; short payloads are zero-padded up to it (46 bytes).
REQ-002 SHALL have parameter MAX_PAY_WORDS, default 375, maximum payload-section words (1498 bytes).
REQ-003 SHALL have ports, in order:
- clk_100_mhz  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame request.
- dst_mac  in  48  destination MAC; captured at accepted start.
- src_mac  in  48  source MAC; captured at accepted start.
- eth_type  in  16  EtherType; captured at accepted start.
- pay_words  in  9  payload words N; captured at accepted start.
- pay_data  in  32  payload word; byte [31:24] goes first on the wire.
- pay_valid  in  1  pay_data valid.
- pay_ready  out  1  builder accepts pay_data this cycle.
- ready_to_write  in  1  downstream word sink idle and preamble queued.
- ready_to_send  in  1  downstream frame queued and awaiting send.
- data_out  out  32  frame word to downstream.
- valid_out  out  1  data_out valid; no backpressure exists.
- last_out  out  1  end-of-frame strobe; data_out ignored when high.
- send  out  1  one-cycle transmit command.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse when downstream finished transmitting.

Function
REQ-004 SHALL sequence states IDLE, WAIT_WR, HDR, PAY, FCS, LAST, SEND, WAIT_DONE; busy = state != IDLE.
REQ-005 SHALL accept start only in IDLE, capture dst_mac, src_mac, eth_type, pay_words, and enter WAIT_WR; start outside IDLE is ignored.
REQ-006 WAIT_WR: SHALL count consecutive cycles with ready_to_write high; a low sample clears the count; on count 3, go to HDR, so first header word is never emitted within 2 cycles of ready_to_write rising.
REQ-007 HDR: SHALL emit on 3 consecutive cycles W0 = dst_mac[47:16], W1 = {dst_mac[15:0], src_mac[47:32]}, W2 = src_mac[31:0], valid_out high each.
REQ-008 PAY: word k (k = 0..Neff-1), Neff = max(N_clamped, MIN_PAY_WORDS); N_clamped = min(pay_words, MAX_PAY_WORDS); N = 0 legal (all pad).
REQ-009 For k < N_clamped, SHALL assert pay_ready and take p_k on pay_valid & pay_ready; for k >= N_clamped, p_k = 32'h0 with pay_ready low, no wait.
REQ-010 SHALL emit {eth_type, p_0[31:16]} for k = 0 and {p_(k-1)[15:0], p_k[31:16]} for k > 0, in the cycle after p_k taken; p_(Neff-1)[15:0] discarded.
REQ-011 With pay_valid held high, SHALL emit one word per cycle with no gap from W2; a pay_valid low cycle yields one valid_out low cycle.
REQ-012 SHALL maintain CRC-32 (poly 04C11DB7 reflected, init FFFFFFFF, final XOR FFFFFFFF) over every emitted byte from W0 through the last payload word, byte [31:24] first, LSB-first per byte.
REQ-013 FCS: on the cycle after the last payload word, SHALL emit the final CRC with its least-significant byte in [31:24] through most-significant in [7:0].
REQ-014 LAST: cycle after FCS, SHALL assert last_out for exactly 1 cycle, valid_out low, data_out 0.
REQ-015 SEND: SHALL wait for ready_to_send high, then assert send for exactly 1 cycle, enter WAIT_DONE.
REQ-016 WAIT_DONE: SHALL wait for ready_to_write low then high, then pulse frame_done 1 cycle and return to IDLE.
REQ-017 Emitted words per frame SHALL equal 4 + Neff, frame bytes 4*Neff + 16, always word-aligned.
REQ-018 All outputs SHALL be registered.

Reset
REQ-019 rst_n low SHALL immediately force IDLE; pay_ready, valid_out, last_out, send, busy, frame_done 0; data_out 32'h0; captured fields, counters, CRC cleared.
REQ-020 Reset mid-frame SHALL abandon the frame with no further output after rst_n rises; next start begins a fresh frame.

Verification
REQ-021 Reset mid-PAY at word 5 -> all outputs 0 same cycle; post-reset start with N=12 yields normal 16-word frame.
REQ-022 N=0, dst=FFFFFFFFFFFF, src=0A0B0C0D0E0F, type=0800, ready_to_write high -> W0=FFFFFFFF, W1=FFFF0A0B, W2=0C0D0E0F, W3=08000000, 12 payload words, FCS matching software CRC-32, last_out, then send.
REQ-023 N=20, pay_valid always high, p_k=k+1 -> W3=00000000, W4=00010000, W5=00020000, ...; 24 back-to-back valid words; pay_ready high exactly 20 cycles.
REQ-024 N=20, pay_valid low every 3rd cycle -> data words identical to REQ-023, one valid_out gap per stall, FCS unchanged.
REQ-025 ready_to_write low at start, pulsing 1,1,0,1,1,1 -> W0 emitted only after third consecutive high sample.
REQ-026 pay_words=400 -> 375 words requested; start pulsed during frame ignored; frame_done only after ready_to_write low-then-high following send.

Source files
------------

// File: rtl/tx_frame_builder.sv
`default_nettype none
// ============================================================================
// Module   : tx_frame_builder
// Brief    : Builds a word-aligned Ethernet frame (header, padded payload,
//            CRC-32 FCS) for a downstream word sink, then issues the send
//            command and waits for the transmit-complete handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tx_frame_builder #(
  parameter int MIN_PAY_WORDS = 12,
  parameter int MAX_PAY_WORDS = 375
) (
  input  logic        clk_100_mhz,
  input  logic        rst_n,
  input  logic        start,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] eth_type,
  input  logic [8:0]  pay_words,
  input  logic [31:0] pay_data,
  input  logic        pay_valid,
  output logic        pay_ready,
  input  logic        ready_to_write,
  input  logic        ready_to_send,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        last_out,
  output logic        send,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_WR   = 3'd1,
    HDR       = 3'd2,
    PAY       = 3'd3,
    FCS       = 3'd4,
    LAST      = 3'd5,
    SEND      = 3'd6,
    WAIT_DONE = 3'd7
  } state_t;

  localparam logic [8:0]  C_MIN_WORDS = 9'(MIN_PAY_WORDS);
  localparam logic [8:0]  C_MAX_WORDS = 9'(MAX_PAY_WORDS);
  localparam logic [31:0] C_CRC_POLY  = 32'hEDB88320;

  state_t      r_state, w_state_nxt;
  logic [47:0] r_dst, r_src;
  logic [15:0] r_type;
  logic [8:0]  r_n_clamp, r_neff, r_k, w_k_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic [15:0] r_prev_lo, w_prev_nxt;
  logic [31:0] r_crc, w_crc_nxt, w_fcs_raw;
  logic        r_seen_low, w_seen_nxt;
  logic [8:0]  w_n_clamp_in, w_neff_in;
  logic        w_capture, w_emit, w_take;
  logic [31:0] w_word, w_pk, w_data_nxt;
  logic        w_valid_nxt, w_last_nxt, w_send_nxt, w_done_nxt, w_pay_ready_nxt;

  // Reflected CRC-32 over one word, byte [31:24] first, each byte LSB first.
  function automatic logic [31:0] crc32_word(input logic [31:0] crc_in,
                                             input logic [31:0] word);
    logic [31:0] c;
    c = crc_in;
    for (int b = 3; b >= 0; b--) begin
      c = c ^ {24'h0, word[b*8 +: 8]};
      for (int i = 0; i < 8; i++) begin
        c = c[0] ? ((c >> 1) ^ C_CRC_POLY) : (c >> 1);
      end
    end
    return c;
  endfunction

  assign w_n_clamp_in = (pay_words > C_MAX_WORDS) ? C_MAX_WORDS : pay_words;
  assign w_neff_in    = (w_n_clamp_in < C_MIN_WORDS) ? C_MIN_WORDS : w_n_clamp_in;
  assign w_fcs_raw    = ~r_crc;

  // State register.
  always_ff @(posedge clk_100_mhz or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state, datapath next values and next output values.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_k_nxt     = r_k;
    w_prev_nxt  = r_prev_lo;
    w_crc_nxt   = r_crc;
    w_seen_nxt  = r_seen_low;
    w_capture   = 1'b0;
    w_emit      = 1'b0;
    w_take      = 1'b0;
    w_word      = 32'h0;
    w_pk        = 32'h0;
    w_data_nxt  = 32'h0;
    w_valid_nxt = 1'b0;
    w_last_nxt  = 1'b0;
    w_send_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = 2'd0;
          w_k_nxt     = 9'd0;
          w_crc_nxt   = 32'hFFFFFFFF;
          w_state_nxt = WAIT_WR;
        end
      end
      WAIT_WR: begin
        // Require three consecutive ready samples before the header starts.
        if (!ready_to_write) begin
          w_cnt_nxt = 2'd0;
        end else if (r_cnt == 2'd2) begin
          w_cnt_nxt   = 2'd0;
          w_state_nxt = HDR;
        end else begin
          w_cnt_nxt = r_cnt + 2'd1;
        end
      end
      HDR: begin
        w_emit = 1'b1;
        case (r_cnt)
          2'd0:    w_word = r_dst[47:16];
          2'd1:    w_word = {r_dst[15:0], r_src[47:32]};
          default: w_word = r_src[31:0];
        endcase
        if (r_cnt == 2'd2) begin
          w_cnt_nxt   = 2'd0;
          w_k_nxt     = 9'd0;
          w_state_nxt = PAY;
        end else begin
          w_cnt_nxt = r_cnt + 2'd1;
        end
      end
      PAY: begin
        // Real words wait for the handshake; pad words are taken at once.
        if (r_k < r_n_clamp) begin
          w_take = pay_valid & pay_ready;
          w_pk   = pay_data;
        end else begin
          w_take = 1'b1;
        end
        if (w_take) begin
          w_emit     = 1'b1;
          w_word     = {(r_k == 9'd0) ? r_type : r_prev_lo, w_pk[31:16]};
          w_prev_nxt = w_pk[15:0];
          w_k_nxt    = r_k + 9'd1;
          if (r_k == r_neff - 9'd1) w_state_nxt = FCS;
        end
      end
      FCS: begin
        w_data_nxt  = {w_fcs_raw[7:0], w_fcs_raw[15:8], w_fcs_raw[23:16], w_fcs_raw[31:24]};
        w_valid_nxt = 1'b1;
        w_state_nxt = LAST;
      end
      LAST: begin
        w_last_nxt  = 1'b1;
        w_state_nxt = SEND;
      end
      SEND: begin
        if (ready_to_send) begin
          w_send_nxt  = 1'b1;
          w_seen_nxt  = 1'b0;
          w_state_nxt = WAIT_DONE;
        end
      end
      default: begin
        // Transmit finished once the sink drops ready and raises it again.
        if (!ready_to_write) begin
          w_seen_nxt = 1'b1;
        end else if (r_seen_low) begin
          w_seen_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
    endcase
    if (w_emit) begin
      w_data_nxt  = w_word;
      w_valid_nxt = 1'b1;
      w_crc_nxt   = crc32_word(r_crc, w_word);
    end
    w_pay_ready_nxt = (w_state_nxt == PAY) && (w_k_nxt < r_n_clamp);
  end

  // Captured fields, counters, CRC and registered outputs.
  always_ff @(posedge clk_100_mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_dst      <= 48'h0;
      r_src      <= 48'h0;
      r_type     <= 16'h0;
      r_n_clamp  <= 9'd0;
      r_neff     <= 9'd0;
      r_k        <= 9'd0;
      r_cnt      <= 2'd0;
      r_prev_lo  <= 16'h0;
      r_crc      <= 32'h0;
      r_seen_low <= 1'b0;
      pay_ready  <= 1'b0;
      data_out   <= 32'h0;
      valid_out  <= 1'b0;
      last_out   <= 1'b0;
      send       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (w_capture) begin
        r_dst     <= dst_mac;
        r_src     <= src_mac;
        r_type    <= eth_type;
        r_n_clamp <= w_n_clamp_in;
        r_neff    <= w_neff_in;
      end
      r_k        <= w_k_nxt;
      r_cnt      <= w_cnt_nxt;
      r_prev_lo  <= w_prev_nxt;
      r_crc      <= w_crc_nxt;
      r_seen_low <= w_seen_nxt;
      pay_ready  <= w_pay_ready_nxt;
      data_out   <= w_data_nxt;
      valid_out  <= w_valid_nxt;
      last_out   <= w_last_nxt;
      send       <= w_send_nxt;
      busy       <= (w_state_nxt != IDLE);
      frame_done <= w_done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_builder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_frame_builder
// Brief    : Directed self-checking bench for tx_frame_builder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_frame_builder;

  logic        clk_100_mhz = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [47:0] dst_mac = 48'h0;
  logic [47:0] src_mac = 48'h0;
  logic [15:0] eth_type = 16'h0;
  logic [8:0]  pay_words = 9'd0;
  logic [31:0] pay_data = 32'h0;
  logic        pay_valid = 1'b0;
  logic        pay_ready;
  logic        ready_to_write = 1'b0;
  logic        ready_to_send = 1'b0;
  logic [31:0] data_out;
  logic        valid_out, last_out, send, busy, frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk_100_mhz = ~clk_100_mhz;

  tx_frame_builder #(.MIN_PAY_WORDS(12), .MAX_PAY_WORDS(375)) dut (
    .clk_100_mhz(clk_100_mhz), .rst_n(rst_n), .start(start),
    .dst_mac(dst_mac), .src_mac(src_mac), .eth_type(eth_type),
    .pay_words(pay_words), .pay_data(pay_data), .pay_valid(pay_valid),
    .pay_ready(pay_ready), .ready_to_write(ready_to_write),
    .ready_to_send(ready_to_send), .data_out(data_out), .valid_out(valid_out),
    .last_out(last_out), .send(send), .busy(busy), .frame_done(frame_done)
  );

  // Payload source: p_k = k+1, or an alternate pattern for the long frame.
  function automatic logic [31:0] pay_word(int k, bit alt);
    if (alt) return {16'(k * 3 + 1), 16'(k ^ 16'hA5A5)};
    return 32'(k + 1);
  endfunction

  int pidx = 0, ncyc_drv = 0, stalls = 0;
  bit stall_en = 0, pat_alt = 0, drv_pv = 0, drv_pr = 0;

  // Payload driver: accounts the handshake of the cycle just ended, then
  // presents the next word, dropping pay_valid every third cycle when stalling.
  always @(negedge clk_100_mhz) begin
    if (drv_pv && drv_pr) pidx++;
    if (drv_pr && !drv_pv) stalls++;
    ncyc_drv++;
    pay_valid = !(stall_en && (ncyc_drv % 3 == 0));
    pay_data  = pay_word(pidx, pat_alt);
    drv_pv    = pay_valid;
    drv_pr    = pay_ready;
  end

  logic [31:0] got[$];
  logic [31:0] exp_q[$];
  int exp_total = 0, pr_cnt = 0, last_cnt = 0, last_bad = 0, send_cnt = 0;
  int done_cnt = 0, gaps = 0, ncyc = 0, last_valid_cyc = 0, last_out_cyc = 0, send_cyc = 0;

  // Output monitor.
  always @(negedge clk_100_mhz) begin
    ncyc++;
    if (valid_out) begin
      got.push_back(data_out);
      last_valid_cyc = ncyc;
    end else if (got.size() > 0 && got.size() < exp_total) begin
      gaps++;
    end
    if (pay_ready) pr_cnt++;
    if (last_out) begin
      last_cnt++;
      last_out_cyc = ncyc;
      if (valid_out || data_out != 32'h0) last_bad++;
    end
    if (send) begin
      send_cnt++;
      send_cyc = ncyc;
    end
    if (frame_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk_100_mhz);
    #1;
  endtask

  function automatic logic [31:0] gw(int i);
    if (i < got.size()) return got[i];
    return 32'hxxxxxxxx;
  endfunction

  // Index of first differing word over the common length, -1 if none.
  function automatic int first_diff();
    int n;
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // Reference frame: header, shifted/padded payload, then software CRC-32.
  task automatic build_expected(logic [47:0] d, logic [47:0] s, logic [15:0] t, int n, bit alt);
    int nc, neff;
    logic [31:0] pk, w, crc;
    logic [15:0] plo;
    logic [7:0]  bv;
    bit fb;
    exp_q.delete();
    nc   = (n > 375) ? 375 : n;
    neff = (nc < 12) ? 12 : nc;
    exp_q.push_back(d[47:16]);
    exp_q.push_back({d[15:0], s[47:32]});
    exp_q.push_back(s[31:0]);
    plo = t;
    for (int k = 0; k < neff; k++) begin
      pk = (k < nc) ? pay_word(k, alt) : 32'h0;
      exp_q.push_back({plo, pk[31:16]});
      plo = pk[15:0];
    end
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < exp_q.size(); i++) begin
      w = exp_q[i];
      for (int b = 3; b >= 0; b--) begin
        bv = w[b*8 +: 8];
        for (int j = 0; j < 8; j++) begin
          fb  = crc[0] ^ bv[j];
          crc = crc >> 1;
          if (fb) crc = crc ^ 32'hEDB88320;
        end
      end
    end
    crc = ~crc;
    exp_q.push_back({crc[7:0], crc[15:8], crc[23:16], crc[31:24]});
    exp_total = exp_q.size();
  endtask

  task automatic kick(logic [47:0] d, logic [47:0] s, logic [15:0] t, int n, bit alt, bit stl);
    build_expected(d, s, t, n, alt);
    got.delete();
    pr_cnt = 0; last_cnt = 0; last_bad = 0; send_cnt = 0; done_cnt = 0;
    gaps = 0; stalls = 0; pidx = 0;
    pat_alt = alt; stall_en = stl;
    dst_mac = d; src_mac = s; eth_type = t; pay_words = 9'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_send(string tag);
    int t = 0;
    while (send_cnt == 0 && t < 3000) begin tick(); t++; end
    checks++;
    if (send_cnt == 0) begin errors++; $display("FAIL %s_send_timeout got=0 exp=1", tag); end
  endtask

  task automatic wait_done(string tag);
    int t = 0;
    ready_to_write = 1'b0;
    tick();
    ready_to_write = 1'b1;
    while (done_cnt == 0 && t < 50) begin tick(); t++; end
    checks++;
    if (done_cnt == 0) begin errors++; $display("FAIL %s_done_timeout got=0 exp=1", tag); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({pay_ready, valid_out, last_out, send, busy, frame_done} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=000000", {pay_ready, valid_out, last_out, send, busy, frame_done});
    end
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=00000000", data_out); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_min_frame();
    int fd;
    ready_to_write = 1'b1; ready_to_send = 1'b1;
    kick(48'hFFFFFFFFFFFF, 48'h0A0B0C0D0E0F, 16'h0800, 0, 0, 0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL min_busy got=%b exp=1", busy); end
    wait_send("min");
    tick(); tick();
    checks++;
    if (got.size() != 16) begin errors++; $display("FAIL min_len got=%0d exp=16", got.size()); end
    checks++;
    if (gw(0) !== 32'hFFFFFFFF) begin errors++; $display("FAIL min_w0 got=%h exp=FFFFFFFF", gw(0)); end
    checks++;
    if (gw(1) !== 32'hFFFF0A0B) begin errors++; $display("FAIL min_w1 got=%h exp=FFFF0A0B", gw(1)); end
    checks++;
    if (gw(2) !== 32'h0C0D0E0F) begin errors++; $display("FAIL min_w2 got=%h exp=0C0D0E0F", gw(2)); end
    checks++;
    if (gw(3) !== 32'h08000000) begin errors++; $display("FAIL min_w3 got=%h exp=08000000", gw(3)); end
    fd = first_diff();
    checks++;
    if (fd != -1) begin errors++; $display("FAIL min_words idx=%0d got=%h exp=%h", fd, got[fd], exp_q[fd]); end
    checks++;
    if (last_cnt != 1 || last_bad != 0) begin
      errors++; $display("FAIL min_last got=%0d/%0d exp=1/0", last_cnt, last_bad);
    end
    checks++;
    if (last_out_cyc != last_valid_cyc + 1) begin
      errors++; $display("FAIL min_last_timing got=%0d exp=%0d", last_out_cyc, last_valid_cyc + 1);
    end
    checks++;
    if (send_cnt != 1 || send_cyc != last_out_cyc + 1) begin
      errors++; $display("FAIL min_send got=%0d@%0d exp=1@%0d", send_cnt, send_cyc, last_out_cyc + 1);
    end
    wait_done("min");
    tick();
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL min_done got=%0d/%b exp=1/0", done_cnt, busy);
    end
  endtask

  logic [31:0] fcs_ref;

  task automatic test_back_to_back();
    int fd;
    kick(48'h112233445566, 48'h778899AABBCC, 16'h0000, 20, 0, 0);
    wait_send("b2b");
    checks++;
    if (got.size() != 24) begin errors++; $display("FAIL b2b_len got=%0d exp=24", got.size()); end
    checks++;
    if (gw(3) !== 32'h00000000) begin errors++; $display("FAIL b2b_w3 got=%h exp=00000000", gw(3)); end
    checks++;
    if (gw(4) !== 32'h00010000) begin errors++; $display("FAIL b2b_w4 got=%h exp=00010000", gw(4)); end
    checks++;
    if (gw(5) !== 32'h00020000) begin errors++; $display("FAIL b2b_w5 got=%h exp=00020000", gw(5)); end
    checks++;
    if (gw(22) !== 32'h00130000) begin errors++; $display("FAIL b2b_w22 got=%h exp=00130000", gw(22)); end
    fd = first_diff();
    checks++;
    if (fd != -1) begin errors++; $display("FAIL b2b_words idx=%0d got=%h exp=%h", fd, got[fd], exp_q[fd]); end
    checks++;
    if (gaps != 0) begin errors++; $display("FAIL b2b_gaps got=%0d exp=0", gaps); end
    checks++;
    if (pr_cnt != 20) begin errors++; $display("FAIL b2b_pay_ready got=%0d exp=20", pr_cnt); end
    fcs_ref = gw(23);
    wait_done("b2b");
  endtask

  task automatic test_stall();
    int fd;
    kick(48'h112233445566, 48'h778899AABBCC, 16'h0000, 20, 0, 1);
    wait_send("stall");
    tick();
    fd = first_diff();
    checks++;
    if (fd != -1 || got.size() != 24) begin
      errors++; $display("FAIL stall_words idx=%0d len=%0d exp_len=24", fd, got.size());
    end
    checks++;
    if (gw(23) !== fcs_ref) begin errors++; $display("FAIL stall_fcs got=%h exp=%h", gw(23), fcs_ref); end
    checks++;
    if (stalls == 0 || gaps != stalls) begin
      errors++; $display("FAIL stall_gaps got=%0d exp=%0d (nonzero)", gaps, stalls);
    end
    checks++;
    if (pr_cnt != 20 + stalls) begin errors++; $display("FAIL stall_pay_ready got=%0d exp=%0d", pr_cnt, 20 + stalls); end
    stall_en = 0;
    wait_done("stall");
  endtask

  task automatic test_wr_qualify();
    bit seq[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int early = 0;
    int fd;
    ready_to_write = 1'b0;
    kick(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h86DD, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      ready_to_write = seq[i];
      tick();
      if (valid_out !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL wr_early got=%0d exp=0", early); end
    tick();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'hA1A2A3A4) begin
      errors++; $display("FAIL wr_w0 got=%b/%h exp=1/A1A2A3A4", valid_out, data_out);
    end
    wait_send("wr");
    fd = first_diff();
    checks++;
    if (fd != -1 || got.size() != 16) begin
      errors++; $display("FAIL wr_words idx=%0d len=%0d exp_len=16", fd, got.size());
    end
    wait_done("wr");
  endtask

  task automatic test_clamp();
    int t = 0;
    int fd;
    kick(48'h001122334455, 48'h66778899AABB, 16'h1234, 400, 1, 0);
    while (got.size() < 50 && t < 500) begin tick(); t++; end
    dst_mac = 48'h0; src_mac = 48'h0; eth_type = 16'hFFFF; pay_words = 9'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_send("clamp");
    fd = first_diff();
    checks++;
    if (fd != -1 || got.size() != 379) begin
      errors++; $display("FAIL clamp_words idx=%0d len=%0d exp_len=379", fd, got.size());
    end
    checks++;
    if (pr_cnt != 375) begin errors++; $display("FAIL clamp_pay_ready got=%0d exp=375", pr_cnt); end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (done_cnt != 0 || busy !== 1'b1) begin
      errors++; $display("FAIL clamp_done_early got=%0d/%b exp=0/1", done_cnt, busy);
    end
    ready_to_write = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL clamp_done_on_low got=%0d exp=0", done_cnt); end
    ready_to_write = 1'b1;
    t = 0;
    while (done_cnt == 0 && t < 20) begin tick(); t++; end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (done_cnt != 1 || busy !== 1'b0 || got.size() != 379) begin
      errors++; $display("FAIL clamp_finish got=%0d/%b/%0d exp=1/0/379", done_cnt, busy, got.size());
    end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    int n0;
    int fd;
    kick(48'h112233445566, 48'h778899AABBCC, 16'h0000, 20, 0, 0);
    while (got.size() < 8 && t < 200) begin tick(); t++; end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pay_ready, valid_out, last_out, send, busy, frame_done} !== 6'b0 || data_out !== 32'h0) begin
      errors++; $display("FAIL rstmid_outputs got=%b/%h exp=000000/00000000",
                         {pay_ready, valid_out, last_out, send, busy, frame_done}, data_out);
    end
    tick(); tick();
    rst_n = 1'b1;
    n0 = got.size();
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (got.size() != n0 || busy !== 1'b0 || send_cnt != 0) begin
      errors++; $display("FAIL rstmid_quiet got=%0d/%b/%0d exp=%0d/0/0", got.size(), busy, send_cnt, n0);
    end
    kick(48'hCAFEBABE0001, 48'h020304050607, 16'h0806, 12, 0, 0);
    wait_send("rstmid");
    fd = first_diff();
    checks++;
    if (fd != -1 || got.size() != 16) begin
      errors++; $display("FAIL rstmid_words idx=%0d len=%0d exp_len=16", fd, got.size());
    end
    wait_done("rstmid");
  endtask

  initial begin
    test_reset();
    test_min_frame();
    test_back_to_back();
    test_stall();
    test_wr_qualify();
    test_clamp();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
